// File: rtl/csr_timer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | csr_timer: CSR-bus slave with two 32-bit compare timers and sticky IRQs. |
// | Timer 1 is built only when CSR_TIMER_TIMER1_EN is defined.               |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module csr_timer #(
  parameter logic [3:0] csr_addr = 4'h0
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [13:0] csr_a,
  input  logic        csr_we,
  input  logic [31:0] csr_di,
  output logic [31:0] csr_do,
  output logic        timer0_irq,
  output logic        timer1_irq
);

  logic        w_sel;
  logic        w_wr;
  logic [2:0]  w_reg;
  logic        unused_addr_bits;

  assign w_sel            = (csr_a[13:10] == csr_addr);
  assign w_wr             = csr_we & w_sel;
  assign w_reg            = csr_a[2:0];
  assign unused_addr_bits = ^csr_a[9:3];

  // Timer 0: CSR writes come last so they override the hardware update.
  logic        r_en0;
  logic        r_ar0;
  logic [31:0] r_cmp0;
  logic [31:0] r_cnt0;
  logic        w_match0;

  assign w_match0 = r_en0 && (r_cnt0 == r_cmp0);

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_en0  <= 1'b0;
      r_ar0  <= 1'b0;
      r_cmp0 <= 32'd0;
      r_cnt0 <= 32'd0;
    end else begin
      if (r_en0) begin
        if (w_match0) begin
          if (r_ar0) r_cnt0 <= 32'd0;
          else       r_en0  <= 1'b0;
        end else begin
          r_cnt0 <= r_cnt0 + 32'd1;
        end
      end
      if (w_wr && (w_reg == 3'd0)) begin
        r_en0 <= csr_di[0];
        r_ar0 <= csr_di[1];
      end
      if (w_wr && (w_reg == 3'd1)) r_cmp0 <= csr_di;
      if (w_wr && (w_reg == 3'd2)) r_cnt0 <= csr_di;
    end
  end

  logic [31:0] w_ctrl1;
  logic [31:0] w_cmp1;
  logic [31:0] w_cnt1;
  logic        w_match1;

`ifdef CSR_TIMER_TIMER1_EN
  logic        r_en1;
  logic        r_ar1;
  logic [31:0] r_cmp1;
  logic [31:0] r_cnt1;

  assign w_match1 = r_en1 && (r_cnt1 == r_cmp1);
  assign w_ctrl1  = {30'd0, r_ar1, r_en1};
  assign w_cmp1   = r_cmp1;
  assign w_cnt1   = r_cnt1;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_en1  <= 1'b0;
      r_ar1  <= 1'b0;
      r_cmp1 <= 32'd0;
      r_cnt1 <= 32'd0;
    end else begin
      if (r_en1) begin
        if (w_match1) begin
          if (r_ar1) r_cnt1 <= 32'd0;
          else       r_en1  <= 1'b0;
        end else begin
          r_cnt1 <= r_cnt1 + 32'd1;
        end
      end
      if (w_wr && (w_reg == 3'd3)) begin
        r_en1 <= csr_di[0];
        r_ar1 <= csr_di[1];
      end
      if (w_wr && (w_reg == 3'd4)) r_cmp1 <= csr_di;
      if (w_wr && (w_reg == 3'd5)) r_cnt1 <= csr_di;
    end
  end
`else
  assign w_match1 = 1'b0;
  assign w_ctrl1  = 32'd0;
  assign w_cmp1   = 32'd0;
  assign w_cnt1   = 32'd0;
`endif

  // A match in the same cycle as a write-1-to-clear keeps the bit set.
  logic [1:0] r_pend;
  logic [1:0] w_clr;

  assign w_clr = (w_wr && (w_reg == 3'd6)) ? csr_di[1:0] : 2'b00;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) r_pend <= 2'b00;
    else         r_pend <= (r_pend & ~w_clr) | {w_match1, w_match0};
  end

  logic [31:0] w_rdata;

  always_comb begin
    w_rdata = 32'd0;
    case (w_reg)
      3'd0:    w_rdata = {30'd0, r_ar0, r_en0};
      3'd1:    w_rdata = r_cmp0;
      3'd2:    w_rdata = r_cnt0;
      3'd3:    w_rdata = w_ctrl1;
      3'd4:    w_rdata = w_cmp1;
      3'd5:    w_rdata = w_cnt1;
      3'd6:    w_rdata = {30'd0, r_pend};
      default: w_rdata = 32'd0;
    endcase
  end

  // Unselected slaves drive zero so the bridge can OR all read buses.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) csr_do <= 32'd0;
    else         csr_do <= w_sel ? w_rdata : 32'd0;
  end

  assign timer0_irq = r_pend[0];
  assign timer1_irq = r_pend[1];

endmodule
`default_nettype wire
